alu_multicycle: RTL and testbench

- Parametrised successor to the single-cycle integer ALU; adds XOR and shift operations, carry/overflow/negative flags, and an iterative low-half multiplier.
- Operation issue and result return use valid/ready handshakes, so the block can sit in the execute stage and stall the pipeline while a multiply is in progress.
- All results and flags are registered.

---
 rtl/alu_multicycle.sv | 129 ++++++++++++
 tb/tb_alu_multicycle.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with registered result/flags and iterative MUL; op issue (opValid/opReady, operands, opcode) in, result/flag return (resValid/resReady) out
module alu_multicycle #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             opValid_in,
  output logic             opReady_out,
  input  logic [WIDTH-1:0] operand1_in,
  input  logic [WIDTH-1:0] operand2_in,
  input  logic [3:0]       aluOpcode_in,
  output logic             resValid_out,
  input  logic             resReady_in,
  output logic [WIDTH-1:0] result_out,
  output logic             zeroFlag_out,
  output logic             negFlag_out,
  output logic             carryFlag_out,
  output logic             ovfFlag_out
);
  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] addb, sum, alu_res, acc_sum;
  logic [SHAMT_W-1:0] shamt;
  logic accept, is_sub, is_arith, is_mul, cout, ovf;
  assign opReady_out   = state_q == IDLE;
  assign resValid_out  = state_q == DONE;
  assign result_out    = result_q;
  assign zeroFlag_out  = zero_q;
  assign negFlag_out   = neg_q;
  assign carryFlag_out = carry_q;
  assign ovfFlag_out   = ovf_q;
  assign accept   = opValid_in && opReady_out;
  assign is_sub   = aluOpcode_in == 4'b0001;
  assign is_mul   = aluOpcode_in == 4'b1000;
  assign is_arith = aluOpcode_in < 4'd2 || aluOpcode_in > 4'd8;
  assign shamt    = operand2_in[SHAMT_W-1:0];
  assign addb     = is_sub ? ~operand2_in : operand2_in;
  assign {cout, sum} = {1'b0, operand1_in} + {1'b0, addb} + (WIDTH+1)'(is_sub);
  assign ovf      = (operand1_in[WIDTH-1] == addb[WIDTH-1]) && (sum[WIDTH-1] != operand1_in[WIDTH-1]);
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    alu_res = sum;
    case (aluOpcode_in)
      4'b0010: alu_res = operand1_in & operand2_in;
      4'b0011: alu_res = operand1_in | operand2_in;
      4'b0100: alu_res = operand1_in ^ operand2_in;
      4'b0101: alu_res = operand1_in << shamt;
      4'b0110: alu_res = operand1_in >> shamt;
      4'b0111: alu_res = WIDTH'($signed(operand1_in) >>> shamt);
      default: alu_res = sum;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mul) begin
          mcand_d  = operand1_in;
          mplier_d = operand2_in;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL_BUSY;
        end else begin
          result_d = alu_res;
          zero_d   = alu_res == '0;
          neg_d    = alu_res[WIDTH-1];
          carry_d  = is_arith && cout;
          ovf_d    = is_arith && ovf;
          state_d  = DONE;
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = acc_sum;
          zero_d   = acc_sum == '0;
          neg_d    = acc_sum[WIDTH-1];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: state_d = resReady_in ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: random and directed checks of alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;
  logic clk = 1'b0, rst = 1'b1;
  logic op_valid = 1'b0, res_ready = 1'b0;
  logic [63:0] op1 = '0, op2 = '0;
  logic [3:0] opc = '0;
  logic op_ready, res_valid, zf, nf, cf, vf;
  logic [63:0] res;
  logic [63:0] last_r;
  logic [3:0] last_f;
  int errs = 0, checks = 0;
  alu_multicycle #(.WIDTH(64)) dut (
    .clk_in(clk), .reset_in(rst), .opValid_in(op_valid), .opReady_out(op_ready),
    .operand1_in(op1), .operand2_in(op2), .aluOpcode_in(opc),
    .resValid_out(res_valid), .resReady_in(res_ready), .result_out(res),
    .zeroFlag_out(zf), .negFlag_out(nf), .carryFlag_out(cf), .ovfFlag_out(vf)
  );
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic [3:0] f);
    logic [64:0] w;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd1: begin
        r = a - b;
        c = a >= b;
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[5:0];
      4'd6: r = a >> b[5:0];
      4'd7: r = 64'($signed(a) >>> b[5:0]);
      4'd8: r = a * b;
      default: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[63:0];
        c = w[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
    endcase
    f = {r == 64'd0, r[63], c, v};
  endfunction
  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 4))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] er;
    logic [3:0] ef;
    int lat;
    model(op, a, b, er, ef);
    check({tag, ".ready"}, 64'(op_ready), 64'd1);
    op_valid = 1'b1;
    opc = op;
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    opc = 4'($urandom);
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), op == 4'd8 ? 64'd65 : 64'd1);
    check({tag, ".res"}, res, er);
    check({tag, ".flags"}, 64'({zf, nf, cf, vf}), 64'(ef));
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'b1;
      opc = 4'd0;
      @(posedge clk);
      #1;
      check({tag, ".hold_res"}, res, er);
      check({tag, ".hold_rdy"}, 64'({op_ready, res_valid}), 64'b01);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, ".idle"}, 64'({op_ready, res_valid}), 64'b10);
    last_r = res;
    last_f = {zf, nf, cf, vf};
  endtask
  initial begin
    #12;
    check("reset.hs", 64'({op_ready, res_valid}), 64'b10);
    check("reset.res", res, 64'd0);
    check("reset.flags", 64'({zf, nf, cf, vf}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("add_wrap", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    check("add_wrap.spec", {last_r[59:0], last_f}, {60'd0, 4'b1010});
    run_op("sub_ovf", 4'd1, 64'h8000_0000_0000_0000, 64'd1, 0);
    check("sub_ovf.spec", last_r, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_ovf.fl", 64'(last_f), 64'b0011);
    run_op("sub_neg", 4'd1, 64'd2, 64'd3, 0);
    check("sub_neg.spec", last_r, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sub_neg.fl", 64'(last_f), 64'b0100);
    run_op("sra", 4'd7, 64'h8000_0000_0000_0000, 64'h41, 0);
    check("sra.spec", last_r, 64'hC000_0000_0000_0000);
    run_op("sll", 4'd5, 64'd1, 64'd63, 0);
    check("sll.spec", last_r, 64'h8000_0000_0000_0000);
    run_op("srl0", 4'd6, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
    check("srl0.spec", last_r, 64'h1234_5678_9ABC_DEF0);
    run_op("mul_ones", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("mul_ones.spec", last_r, 64'd1);
    run_op("mul_zero", 4'd8, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
    check("mul_zero.spec", 64'(last_f[3]), 64'd1);
    run_op("xor_hold", 4'd4, 64'hF0F0, 64'hFF00, 10);
    check("xor_hold.spec", last_r, 64'h0FF0);
    op_valid = 1'b1;
    opc = 4'd8;
    op1 = 64'd7;
    op2 = 64'd9;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("mid_mul.busy", 64'({op_ready, res_valid}), 64'b00);
    rst = 1'b1;
    #1;
    check("mid_mul.hs", 64'({op_ready, res_valid}), 64'b10);
    check("mid_mul.res", res, 64'd0);
    check("mid_mul.flags", 64'({zf, nf, cf, vf}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("mul_3x5", 4'd8, 64'd3, 64'd5, 0);
    check("mul_3x5.spec", last_r, 64'd15);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("stray_ready", 64'({op_ready, res_valid}), 64'b10);
    for (int n = 0; n < 60; n++)
      run_op($sformatf("rand%0d", n), 4'($urandom_range(0, 15)), rnd(), rnd(), $urandom_range(0, 3));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
